multdiv_unit: RTL and testbench

Multi-cycle signed 32-bit multiply/divide unit in the execute stage. Runs beside the single-cycle ALU/shifter path. It accepts one operation per start pulse and iterates one bit per clock: radix-2 Booth for multiply, non-restoring on magnitudes for divide. It pulses a ready strobe with the result and an exception flag. The pipeline stalls on it while it is busy.

---
 rtl/multdiv_unit.sv | 130 +++++++++++++
 tb/tb_multdiv_unit.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/multdiv_unit.sv
// Signed 32-bit multi-cycle multiply (radix-2 Booth) / divide (non-restoring on magnitudes).
// Latency 33 cycles (mult) / 34 cycles (div) from start edge to the one-cycle RDY strobe.
module multdiv_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY
);
    typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

    state_t      r_state, w_next;
    logic [5:0]  r_cnt;
    logic [32:0] r_acc;
    logic [31:0] r_lo, r_a;
    logic        r_qm1, r_neg, r_dz, r_ovf;
    logic [31:0] r_result;
    logic        r_exc;

    logic        w_accept, w_go_mult, w_go_div, w_mult_ovf;
    logic [32:0] w_sext_a, w_booth, w_dsor, w_dsh, w_dnext;
    logic [31:0] w_absa, w_absb;

    always_comb begin
        w_accept  = (r_state == IDLE) || (r_state == DONE);
        w_go_mult = w_accept && ctrl_MULT;
        w_go_div  = w_accept && !ctrl_MULT && ctrl_DIV;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (w_go_mult)     w_next = MULT;
                else if (w_go_div) w_next = DIV;
                else               w_next = IDLE;
            end
            MULT:    if (r_cnt == 6'd32) w_next = DONE;
            DIV:     if (r_cnt == 6'd33) w_next = DONE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_sext_a = {r_a[31], r_a};
        case ({r_lo[0], r_qm1})
            2'b01:   w_booth = r_acc + w_sext_a;
            2'b10:   w_booth = r_acc - w_sext_a;
            default: w_booth = r_acc;
        endcase
        // Remainder wraps mod 2^33; the true value always lands back in [-D, D).
        w_dsor     = {1'b0, r_a};
        w_dsh      = {r_acc[31:0], r_lo[31]};
        w_dnext    = r_acc[32] ? (w_dsh + w_dsor) : (w_dsh - w_dsor);
        w_absa     = data_operandA[31] ? -data_operandA : data_operandA;
        w_absb     = data_operandB[31] ? -data_operandB : data_operandB;
        w_mult_ovf = (r_acc != {33{r_lo[31]}});
    end

    always_ff @(posedge clock) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_lo     <= '0;
            r_a      <= '0;
            r_qm1    <= 1'b0;
            r_neg    <= 1'b0;
            r_dz     <= 1'b0;
            r_ovf    <= 1'b0;
            r_result <= '0;
            r_exc    <= 1'b0;
        end else if (w_go_mult) begin
            r_acc <= '0;
            r_lo  <= data_operandB;
            r_a   <= data_operandA;
            r_qm1 <= 1'b0;
            r_cnt <= '0;
        end else if (w_go_div) begin
            r_acc <= '0;
            r_lo  <= w_absa;
            r_a   <= w_absb;
            r_neg <= data_operandA[31] ^ data_operandB[31];
            r_dz  <= (data_operandB == 32'd0);
            r_ovf <= (data_operandA == 32'h8000_0000) && (data_operandB == 32'hFFFF_FFFF);
            r_cnt <= '0;
        end else begin
            case (r_state)
                MULT: begin
                    if (r_cnt < 6'd32) begin
                        r_acc <= {w_booth[32], w_booth[32:1]};
                        r_lo  <= {w_booth[0], r_lo[31:1]};
                        r_qm1 <= r_lo[0];
                        r_cnt <= r_cnt + 6'd1;
                    end else begin
                        r_result <= r_lo;
                        r_exc    <= w_mult_ovf;
                    end
                end
                DIV: begin
                    if (r_cnt < 6'd32) begin
                        r_acc <= w_dnext;
                        r_lo  <= {r_lo[30:0], ~w_dnext[32]};
                        r_cnt <= r_cnt + 6'd1;
                    end else if (r_cnt == 6'd32) begin
                        if (r_acc[32]) r_acc <= r_acc + w_dsor;
                        r_lo  <= r_neg ? -r_lo : r_lo;
                        r_cnt <= r_cnt + 6'd1;
                    end else begin
                        r_result <= r_dz ? 32'd0 : r_lo;
                        r_exc    <= r_dz | r_ovf;
                    end
                end
                default: ;
            endcase
        end
    end

    assign data_result    = r_result;
    assign data_exception = r_exc;
    assign data_resultRDY = (r_state == DONE);
endmodule

// File: tb/tb_multdiv_unit.sv
// Bench for multdiv_unit: directed table, random ops against a 64-bit arithmetic model, corner sequences.
module tb_multdiv_unit;
    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] data_operandA, data_operandB;
    logic        ctrl_MULT, ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception, data_resultRDY;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    multdiv_unit dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc = cyc + 1;

    typedef struct {
        bit          is_div;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_res;
        bit          exp_exc;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    // Reference: plain 64-bit signed arithmetic, division truncating toward zero.
    function automatic void model(input bit d, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output bit e);
        longint sa, sb, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!d) begin
            p = sa * sb;
            r = p[31:0];
            e = (p != longint'($signed(p[31:0])));
        end else if (b == 32'd0) begin
            r = 32'd0;
            e = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r = 32'h8000_0000;
            e = 1'b1;
        end else begin
            p = sa / sb;
            r = p[31:0];
            e = 1'b0;
        end
    endfunction

    task automatic start(input bit d, input logic [31:0] a, input logic [31:0] b, output int e0);
        @(negedge clock);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = !d;
        ctrl_DIV      = d;
        @(posedge clock);
        #1;
        e0        = cyc;
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
    endtask

    task automatic wait_rdy(input int e0, output int lat);
        lat = -1;
        for (int n = 0; n < 60; n++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) begin
                lat = cyc - e0;
                break;
            end
        end
    endtask

    task automatic do_op(input string nm, input bit d, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input bit ee);
        int e0, lat;
        start(d, a, b, e0);
        wait_rdy(e0, lat);
        chk({nm, ".latency"}, lat, d ? 34 : 33);
        chk({nm, ".result"}, data_result, er);
        chk({nm, ".exception"}, {31'd0, data_exception}, {31'd0, ee});
        @(posedge clock);
        #1;
        chk({nm, ".rdy_drop"}, {31'd0, data_resultRDY}, 32'd0);
        chk({nm, ".hold"}, data_result, er);
    endtask

    initial begin
        int e0, lat, rdy_seen;
        logic [31:0] ra, rb, er;
        bit d, ee;

        tbl[0] = '{0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 0};
        tbl[1] = '{0, 32'h0001_0000,  32'h0001_0000, 32'h0000_0000, 1};
        tbl[2] = '{0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0001, 0};
        tbl[3] = '{1, 32'hFFFF_FF9C,  32'd7,         32'hFFFF_FFF2, 0};
        tbl[4] = '{1, 32'd100,        32'hFFFF_FFF9, 32'hFFFF_FFF2, 0};
        tbl[5] = '{1, 32'd5,          32'd0,         32'h0000_0000, 1};
        tbl[6] = '{1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
        tbl[7] = '{0, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
        tbl[8] = '{1, 32'h8000_0000,  32'd1,         32'h8000_0000, 0};

        reset = 1'b1; ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
        data_operandA = '0; data_operandB = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        chk("reset.rdy", {31'd0, data_resultRDY}, 32'd0);
        chk("reset.result", data_result, 32'd0);
        chk("reset.exception", {31'd0, data_exception}, 32'd0);

        for (int i = 0; i < 9; i++)
            do_op($sformatf("vec%0d", i), tbl[i].is_div, tbl[i].a, tbl[i].b,
                  tbl[i].exp_res, tbl[i].exp_exc);

        for (int i = 0; i < 30; i++) begin
            d  = $urandom_range(0, 1);
            ra = $urandom >> $urandom_range(0, 31);
            rb = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) ra = -ra;
            if ($urandom_range(0, 1) == 1) rb = -rb;
            if ($urandom_range(0, 9) == 0) rb = 32'd0;
            model(d, ra, rb, er, ee);
            do_op($sformatf("rand%0d", i), d, ra, rb, er, ee);
        end

        // Start inputs and operand changes while busy are ignored.
        start(0, 32'd3, 32'd4, e0);
        repeat (10) @(negedge clock);
        ctrl_DIV = 1'b1; data_operandA = 32'd100; data_operandB = 32'd5;
        @(negedge clock);
        ctrl_DIV = 1'b0; data_operandA = 32'd9; data_operandB = 32'd9;
        wait_rdy(e0, lat);
        chk("busy.latency", lat, 33);
        chk("busy.result", data_result, 32'd12);

        // New start pulsed during the RDY cycle.
        start(0, 32'd2, 32'd2, e0);
        chk("b2b.rdy_drop", {31'd0, data_resultRDY}, 32'd0);
        wait_rdy(e0, lat);
        chk("b2b.latency", lat, 33);
        chk("b2b.result", data_result, 32'd4);

        // Reset mid-divide aborts the op without a strobe.
        start(1, 32'd1000, 32'd7, e0);
        while (cyc < e0 + 14) @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        rdy_seen = 0;
        for (int n = 0; n < 50; n++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) rdy_seen++;
        end
        chk("abort.no_rdy", rdy_seen, 0);
        chk("abort.result", data_result, 32'd0);
        chk("abort.exception", {31'd0, data_exception}, 32'd0);
        do_op("post_reset", 0, 32'd6, 32'd6, 32'd36, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
